// File: rtl/alu_pkg.sv
// Shared definitions for the alu engine and its command issuer.
//   OP_ADD / OP_MUL : the two opcodes the ALU implements
//   ADDR_W / DATA_W : memory word address and data widths
//   issuer_state_t  : issuer FSM states
//   is_legal_op     : true for opcodes the ALU implements
package alu_pkg;

   localparam logic [7:0] OP_ADD = 8'h05;
   localparam logic [7:0] OP_MUL = 8'h06;
   localparam int         OP_W   = 8;
   localparam int         ADDR_W = 20;
   localparam int         DATA_W = 16;
   localparam int         CMD_W  = OP_W + ADDR_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } issuer_state_t;

   function automatic logic is_legal_op(input logic [7:0] op);
      return (op == OP_ADD) || (op == OP_MUL);
   endfunction

endpackage

// File: rtl/alu_issuer_fifo.sv
// Synchronous command FIFO for alu_issuer.
//   clk, rst_n : clock, async active-low reset (pointers only)
//   i_push     : write i_wdata (ignored when full)
//   i_pop      : drop head entry (ignored when empty)
//   o_rdata    : head entry
//   o_full     : no free entry
//   o_empty    : no valid entry
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module alu_issuer_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 28
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_do_push;
   logic             w_do_pop;

   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
   end

   // Storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
   end

endmodule

// File: rtl/alu_issuer.sv
// Command initiator for the alu operand/write-back engine.
//   clk, rst_n            : clock, async active-low reset
//   cmd_valid/cmd_ready   : command handshake (cmd_ready = FIFO not full)
//   cmd_opcode, cmd_addr  : command payload
//   alu_start/opcode/addr : registered ALU request; addr held until WAIT exits
//   alu_ready             : ALU idle
//   busy                  : FSM active or commands queued
//   done, done_count      : completion pulse and wrapping count
//   err, err_count        : rejected-opcode pulse and count
// Optional macro ALU_ISSUER_OPCHK_EN: drop commands whose opcode is not
// add/multiply and report them on err/err_count (tied 0 otherwise).
//
// state | meaning
// IDLE  | waiting for a queued command and an idle ALU
// ISSUE | alu_start high; ALU samples it at the next edge
// WAIT  | ALU reading/writing at alu_addr; exit on alu_ready
module alu_issuer
   import alu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [OP_W-1:0]   cmd_opcode,
   input  logic [ADDR_W-1:0] cmd_addr,
   output logic              alu_start,
   output logic [OP_W-1:0]   alu_opcode,
   output logic [ADDR_W-1:0] alu_addr,
   input  logic              alu_ready,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  done_count,
   output logic              err,
   output logic [CNT_W-1:0]  err_count
);

   issuer_state_t     r_state;
   issuer_state_t     w_next;
   logic              w_pop;
   logic              w_done_set;
   logic              w_full;
   logic              w_empty;
   logic [CMD_W-1:0]  w_head;
   logic              w_accept;
   logic              w_push;
   logic              r_start;
   logic [OP_W-1:0]   r_opcode;
   logic [ADDR_W-1:0] r_addr;
   logic              r_done;
   logic [CNT_W-1:0]  r_done_count;

   assign w_accept  = cmd_valid && !w_full;
   assign cmd_ready = !w_full;

   alu_issuer_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (CMD_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_wdata ({cmd_opcode, cmd_addr}),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_pop      = 1'b0;
      w_done_set = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_empty && alu_ready) begin
               w_pop  = 1'b1;
               w_next = ISSUE;
            end
         end
         ISSUE: w_next = WAIT;
         WAIT: begin
            if (alu_ready) begin
               w_done_set = 1'b1;
               w_next     = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // The opcode/address registers load only on pop, so they stay put
   // from ISSUE through the edge that leaves WAIT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_start      <= 1'b0;
         r_opcode     <= '0;
         r_addr       <= '0;
         r_done       <= 1'b0;
         r_done_count <= '0;
      end else begin
         r_start <= w_pop;
         r_done  <= w_done_set;
         if (w_pop) begin
            r_opcode <= w_head[CMD_W-1:ADDR_W];
            r_addr   <= w_head[ADDR_W-1:0];
         end
         if (w_done_set) r_done_count <= r_done_count + CNT_W'(1);
      end
   end

   assign alu_start  = r_start;
   assign alu_opcode = r_opcode;
   assign alu_addr   = r_addr;
   assign done       = r_done;
   assign done_count = r_done_count;
   assign busy       = (r_state != IDLE) || !w_empty;

`ifdef ALU_ISSUER_OPCHK_EN
   logic             r_err;
   logic [CNT_W-1:0] r_err_count;
   logic             w_illegal;

   assign w_illegal = !is_legal_op(cmd_opcode);
   // Illegal commands complete the handshake but never enter the FIFO.
   assign w_push    = w_accept && !w_illegal;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err       <= 1'b0;
         r_err_count <= '0;
      end else begin
         r_err <= w_accept && w_illegal;
         if (w_accept && w_illegal) r_err_count <= r_err_count + CNT_W'(1);
      end
   end

   assign err       = r_err;
   assign err_count = r_err_count;
`else
   assign w_push    = w_accept;
   assign err       = 1'b0;
   assign err_count = '0;
`endif

endmodule

// File: tb/tb_alu_issuer.sv
module tb_alu_issuer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [7:0]  cmd_opcode = '0;
   logic [19:0] cmd_addr = '0;
   logic        alu_start;
   logic [7:0]  alu_opcode;
   logic [19:0] alu_addr;
   logic        alu_ready;
   logic        busy;
   logic        done;
   logic [15:0] done_count;
   logic        err;
   logic [15:0] err_count;

   alu_issuer #(.DEPTH(4), .CNT_W(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_opcode (cmd_opcode),
      .cmd_addr   (cmd_addr),
      .alu_start  (alu_start),
      .alu_opcode (alu_opcode),
      .alu_addr   (alu_addr),
      .alu_ready  (alu_ready),
      .busy       (busy),
      .done       (done),
      .done_count (done_count),
      .err        (err),
      .err_count  (err_count)
   );

   always #5 clk = ~clk;

   // ALU stub: read op1, read op2, write back, all at the live address.
   logic [15:0] mem [256];
   logic [1:0]  a_st;
   logic [7:0]  a_op;
   logic [15:0] a_op1, a_op2;
   logic        stub_hold = 1'b0;
   logic        pre_we = 1'b0;
   logic [7:0]  pre_addr = '0;
   logic [15:0] pre_data = '0;

   function automatic logic [15:0] alu_result(input logic [7:0] op,
                                              input logic [15:0] a,
                                              input logic [15:0] b);
      logic [31:0] p;
      p = a * b;
      if (op == 8'h05) return a + b;
      if (op == 8'h06) return p[15:0];
      return 16'h0000;
   endfunction

   assign alu_ready = (a_st == 2'd0) && !stub_hold;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_st <= 2'd0;
      end else begin
         if (pre_we) mem[pre_addr] <= pre_data;
         case (a_st)
            2'd0: if (alu_start) begin
               a_op  <= alu_opcode;
               a_op1 <= mem[alu_addr[7:0]];
               a_st  <= 2'd1;
            end
            2'd1: begin
               a_op2 <= mem[alu_addr[7:0]];
               a_st  <= 2'd2;
            end
            default: begin
               mem[alu_addr[7:0]] <= alu_result(a_op, a_op1, a_op2);
               a_st <= 2'd0;
            end
         endcase
      end
   end

   // Monitor
   int          cyc = 0;
   int          start_cnt = 0;
   int          done_cnt = 0;
   int          glitch = 0;
   int          held = 0;
   int          held_last = 0;
   bit          in_op = 0;
   logic [19:0] hold_addr;
   logic [19:0] start_addr_q[$];
   int          start_cyc_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (done) done_cnt++;
      if (alu_start) begin
         start_cnt++;
         start_addr_q.push_back(alu_addr);
         start_cyc_q.push_back(cyc);
         in_op     = 1;
         hold_addr = alu_addr;
         held      = 1;
      end else if (done || !rst_n) begin
         if (in_op && done) held_last = held;
         in_op = 0;
      end else if (in_op) begin
         if (alu_addr !== hold_addr) glitch++;
         held++;
      end
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_cmd_ready"},  cmd_ready, 1);
      chk({tag, "_alu_start"},  alu_start, 0);
      chk({tag, "_alu_opcode"}, alu_opcode, 0);
      chk({tag, "_alu_addr"},   alu_addr, 0);
      chk({tag, "_busy"},       busy, 0);
      chk({tag, "_done"},       done, 0);
      chk({tag, "_done_count"}, done_count, 0);
      chk({tag, "_err"},        err, 0);
      chk({tag, "_err_count"},  err_count, 0);
   endtask

   task automatic preload(input logic [7:0] a, input logic [15:0] d);
      @(negedge clk);
      pre_we = 1; pre_addr = a; pre_data = d;
      @(negedge clk);
      pre_we = 0;
   endtask

   // Push one command at the next edge; returns the cycle number after it.
   task automatic push1(input logic [7:0] op, input logic [19:0] a, output int t);
      @(negedge clk);
      cmd_valid = 1; cmd_opcode = op; cmd_addr = a;
      @(negedge clk);
      cmd_valid = 0;
      t = cyc;
   endtask

   task automatic wait_done(input int bound, output bit ok, output int t);
      ok = 0;
      t  = 0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (done) begin
            ok = 1;
            t  = cyc;
            break;
         end
      end
   endtask

   task automatic wait_ops(input int target, input int bound, output bit ok);
      ok = 0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         #1;
         if (done_cnt >= target) begin
            ok = 1;
            break;
         end
      end
   endtask

   typedef struct {
      logic [7:0]  op;
      logic [19:0] addr;
      logic [15:0] init;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int          t0, td, s0, g0, d0, sb;
      logic [15:0] dc0;
      bit          ok;

      vecs[0] = '{8'h05, 20'h00010, 16'h0003, 16'h0006};
      vecs[1] = '{8'h06, 20'h00020, 16'h0007, 16'h0031};
      vecs[2] = '{8'h05, 20'h00030, 16'h8001, 16'h0002};
      vecs[3] = '{8'h06, 20'h00040, 16'h0100, 16'h0000};

      #1;
      chk_reset_vals("reset");
      repeat (2) @(negedge clk);
      rst_n = 1;

      // Single operations
      for (int v = 0; v < 4; v++) begin
         preload(vecs[v].addr[7:0], vecs[v].init);
         s0 = start_cnt; g0 = glitch; dc0 = done_count;
         push1(vecs[v].op, vecs[v].addr, t0);
         wait_done(20, ok, td);
         chk($sformatf("v%0d_done_seen", v), ok, 1);
         chk($sformatf("v%0d_latency", v), td - t0, 5);
         @(negedge clk);
         chk($sformatf("v%0d_done_width", v), done, 0);
         #1;
         chk($sformatf("v%0d_starts", v), start_cnt - s0, 1);
         chk($sformatf("v%0d_addr_held", v), held_last, 4);
         chk($sformatf("v%0d_addr_stable", v), glitch - g0, 0);
         chk($sformatf("v%0d_mem", v), mem[vecs[v].addr[7:0]], vecs[v].exp);
         chk($sformatf("v%0d_done_count", v), done_count, dc0 + 16'd1);
      end

      // Back-to-back multiplies
      for (int i = 0; i < 4; i++) preload(8'h60 + 8'(i), 16'(i + 2));
      sb = start_addr_q.size(); d0 = done_cnt; dc0 = done_count;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("b2b_ready%0d", i), cmd_ready, 1);
         cmd_valid = 1; cmd_opcode = 8'h06; cmd_addr = 20'h00060 + 20'(i);
      end
      @(negedge clk);
      cmd_valid = 0;
      wait_ops(d0 + 4, 60, ok);
      chk("b2b_ops_done", ok, 1);
      if (ok) begin
         for (int i = 0; i < 3; i++)
            chk($sformatf("b2b_spacing%0d", i), start_cyc_q[sb+i+1] - start_cyc_q[sb+i], 5);
         chk("b2b_mem0", mem[8'h60], 16'd4);
         chk("b2b_mem3", mem[8'h63], 16'd25);
         chk("b2b_done_count", done_count, dc0 + 16'd4);
      end

      // Full FIFO with ALU held busy
      @(negedge clk);
      stub_hold = 1;
      sb = start_addr_q.size(); d0 = done_cnt; s0 = start_cnt;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("full_ready%0d", i), cmd_ready, 1);
         cmd_valid = 1; cmd_opcode = 8'h05; cmd_addr = 20'h00070 + 20'(i);
      end
      @(negedge clk);
      chk("full_ready_low", cmd_ready, 0);
      chk("full_busy", busy, 1);
      cmd_addr = 20'h00074;
      repeat (3) @(negedge clk);
      chk("full_still_low", cmd_ready, 0);
      chk("full_no_start", start_cnt - s0, 0);
      stub_hold = 0;
      ok = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (cmd_ready) begin
            ok = 1;
            chk("full_ready_after_pop", i, 0);
            break;
         end
      end
      chk("full_ready_returned", ok, 1);
      @(negedge clk);
      cmd_valid = 0;
      wait_ops(d0 + 5, 120, ok);
      chk("full_ops_done", ok, 1);
      if (ok) begin
         for (int i = 0; i < 5; i++)
            chk($sformatf("full_order%0d", i), start_addr_q[sb+i], 20'h00070 + 20'(i));
      end
      @(negedge clk);
      chk("full_idle_busy", busy, 0);

      // Reset during WAIT
      preload(8'h80, 16'h0009);
      s0 = start_cnt;
      @(negedge clk);
      cmd_valid = 1; cmd_opcode = 8'h05; cmd_addr = 20'h00080;
      @(negedge clk);
      cmd_addr = 20'h00081; cmd_opcode = 8'h06;
      @(negedge clk);
      cmd_valid = 0;
      @(negedge clk);
      #1;
      chk("rst_op_started", start_cnt - s0, 1);
      rst_n = 0;
      #1;
      chk_reset_vals("midrst");
      repeat (2) @(negedge clk);
      rst_n = 1;
      s0 = start_cnt; d0 = done_cnt;
      repeat (12) @(negedge clk);
      #1;
      chk("midrst_no_done", done_cnt - d0, 0);
      chk("midrst_no_start", start_cnt - s0, 0);
      chk("midrst_mem_kept", mem[8'h80], 16'h0009);
      chk("midrst_busy", busy, 0);

      // done_count wrap
      @(negedge clk);
      force dut.r_done_count = 16'hFFFF;
      #1;
      release dut.r_done_count;
      chk("wrap_preset", done_count, 16'hFFFF);
      preload(8'h90, 16'h0001);
      push1(8'h05, 20'h00090, t0);
      wait_done(20, ok, td);
      chk("wrap_done_seen", ok, 1);
      @(negedge clk);
      chk("wrap_count", done_count, 16'h0000);
      chk("wrap_mem", mem[8'h90], 16'h0002);

      // Unsupported opcode
      preload(8'h50, 16'h1234);
      s0 = start_cnt;
`ifdef ALU_ISSUER_OPCHK_EN
      push1(8'h07, 20'h00050, t0);
      chk("opchk_err_pulse", err, 1);
      chk("opchk_err_count", err_count, 16'd1);
      @(negedge clk);
      chk("opchk_err_width", err, 0);
      repeat (8) @(negedge clk);
      #1;
      chk("opchk_no_start", start_cnt - s0, 0);
      chk("opchk_mem_kept", mem[8'h50], 16'h1234);
      chk("opchk_busy", busy, 0);
`else
      push1(8'h07, 20'h00050, t0);
      wait_done(20, ok, td);
      chk("op07_done_seen", ok, 1);
      @(negedge clk);
      #1;
      chk("op07_start", start_cnt - s0, 1);
      chk("op07_mem_zero", mem[8'h50], 16'h0000);
      chk("op07_err", err, 0);
      chk("op07_err_count", err_count, 16'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got timeout, required finish");
      $fatal(1, "timeout");
   end

endmodule
